// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundles the fetch port, the data port and the shared memory
//                port of mem_arbiter. The slave modport is the arbiter's view;
//                the master modport is the view of the surrounding system.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Instruction-fetch port
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_done;

    // Data port
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_done;

    // Timeout indication
    logic              err;

    // Shared single-port memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               mem_rdata, mem_ack,
        output imem_rdata, imem_done, dmem_rdata, dmem_done, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               mem_rdata, mem_ack,
        input  imem_rdata, imem_done, dmem_rdata, dmem_done, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester arbiter (instruction fetch, data) in front of a
//                single-port memory. One transfer at a time, completion by
//                mem_ack or by a cycle-count timeout (flagged on err).
//                Default arbitration is fixed priority, data over fetch.
//                Define MEMARB_ROUNDROBIN_EN to alternate between requesters
//                when both are eligible.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         sysclk,
    input  logic         nrst_in,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_XFER = 2'd1;
    localparam logic [1:0] D_XFER = 2'd2;

    // The counter starts at 0 in the first transfer cycle, so the transfer
    // times out at the end of the cycle in which it holds TIMEOUT-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [15:0]       cycle_cnt;
    logic              elig_i;
    logic              elig_d;
    logic              grant_i;
    logic              grant_d;
    logic              timed_out;
    logic [ADDR_W-1:0] grant_addr;

    // A requester whose done is visible this cycle is still holding its
    // request for the transfer just finished; it must not be served again.
    assign elig_i = bus.imem_req && !bus.imem_done;
    assign elig_d = bus.dmem_req && !bus.dmem_done;

`ifdef MEMARB_ROUNDROBIN_EN
    // 1 when the most recent grant went to dmem. The reset value makes imem
    // the winner of the first tie after reset.
    logic last_dmem;

    // Tie goes to the requester that was not granted last
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (elig_i && elig_d) begin
            grant_i = last_dmem;
            grant_d = !last_dmem;
        end else begin
            grant_i = elig_i;
            grant_d = elig_d;
        end
    end

    // Pointer follows every grant issued from IDLE
    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            last_dmem <= 1'b1;
        end else if ((state == IDLE) && (grant_i || grant_d)) begin
            last_dmem <= grant_d;
        end
    end
`else
    // Fixed priority: data port wins whenever it is eligible
    assign grant_d = elig_d;
    assign grant_i = elig_i && !elig_d;
`endif

    assign grant_addr = grant_d ? bus.dmem_addr : bus.imem_addr;
    assign timed_out  = (cycle_cnt == TMO_LAST);

    // Transfer sequencing: grant, hold the memory command, release on ack/timeout
    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            state         <= IDLE;
            cycle_cnt     <= 16'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        state        <= grant_d ? D_XFER : I_XFER;
                        cycle_cnt    <= 16'd0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= grant_addr;
                        // Fetches are always reads and carry no write data
                        bus.mem_we    <= grant_d ? bus.dmem_we : 1'b0;
                        bus.mem_wdata <= grant_d ? bus.dmem_wdata : 32'd0;
                    end
                end
                I_XFER, D_XFER: begin
                    if (bus.mem_ack || timed_out) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end else begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulses and read-data capture; ack takes precedence over timeout
    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            bus.imem_rdata <= 32'd0;
            bus.dmem_rdata <= 32'd0;
            bus.imem_done  <= 1'b0;
            bus.dmem_done  <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.imem_done <= 1'b0;
            bus.dmem_done <= 1'b0;
            bus.err       <= 1'b0;
            if (state == I_XFER) begin
                if (bus.mem_ack) begin
                    bus.imem_done  <= 1'b1;
                    bus.imem_rdata <= bus.mem_rdata;
                end else if (timed_out) begin
                    bus.imem_done <= 1'b1;
                    bus.err       <= 1'b1;
                end
            end else if (state == D_XFER) begin
                if (bus.mem_ack) begin
                    bus.dmem_done <= 1'b1;
                    // Writes leave the last read value in place
                    if (!bus.mem_we) begin
                        bus.dmem_rdata <= bus.mem_rdata;
                    end
                end else if (timed_out) begin
                    bus.dmem_done <= 1'b1;
                    bus.err       <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter (TIMEOUT = 4). Stimulus
//                pushes expected memory commands and completions into queues;
//                a negedge monitor pops and compares whenever the DUT
//                presents mem_req or a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          len;
    } cmd_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic sysclk = 1'b0;
    logic nrst_in;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .sysclk (sysclk),
        .nrst_in(nrst_in),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    int   n_cmp = 0;
    int   n_bad = 0;
    cmd_t exp_c[$];
    rsp_t exp_i[$];
    rsp_t exp_d[$];

    int ack_delay = 0;   // cycles of mem_req before ack; -1 = never ack
    bit force_ack = 1'b0;

    // Memory contents: one known instruction word, everything else ~addr
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return ~a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input bit cw, input int len);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = wd; c.chk_wdata = cw; c.len = len;
        exp_c.push_back(c);
    endtask

    task automatic push_rsp(input bit is_d, input logic [31:0] rd, input logic e);
        rsp_t r;
        r.rdata = rd; r.err = e;
        if (is_d) exp_d.push_back(r); else exp_i.push_back(r);
    endtask

    // Waits (bounded) for a done pulse; optionally checks cycles from the call
    task automatic wait_done(input bit is_d, input int exp_lat, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge sysclk);
            if ((is_d ? bus.dmem_done : bus.imem_done) === 1'b1) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s wait: no done after %0d cycles, want a done pulse", name, n);
        end else if (exp_lat >= 0) begin
            n_cmp++;
            if (n != exp_lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d cycles want %0d", name, n, exp_lat);
            end
        end
        @(posedge sysclk);
        #1;
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req
    initial begin : p_mem
        int  wait_cnt;
        bit  acked;
        wait_cnt = 0;
        acked = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge sysclk);
            #1;
            bus.mem_ack = force_ack;
            bus.mem_rdata = force_ack ? 32'h1234_5678 : 32'hDEAD_BEEF;
            if (bus.mem_req === 1'b1) begin
                if (!acked && ack_delay >= 0 && wait_cnt == ack_delay) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    acked = 1'b1;
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                acked = 1'b0;
            end
        end
    end

    // Monitor: compares every presented command and completion to the queues
    logic        was_req = 1'b0;
    int          cur_len = 0;
    bit          unstable = 1'b0;
    cmd_t        cur;
    logic        h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        prev_idone = 1'b0;
    logic        prev_ddone = 1'b0;

    always @(negedge sysclk) begin
        rsp_t r;
        if (bus.imem_done === 1'b1) begin
            n_cmp++;
            if (exp_i.size() == 0 || prev_idone === 1'b1) begin
                n_bad++;
                $display("FAIL imem_done unexpected: got done=1 want no done");
            end else begin
                r = exp_i.pop_front();
                if (bus.imem_rdata !== r.rdata || bus.err !== r.err) begin
                    n_bad++;
                    $display("FAIL imem_rsp: got rdata=%h err=%b want rdata=%h err=%b",
                             bus.imem_rdata, bus.err, r.rdata, r.err);
                end
            end
        end
        if (bus.dmem_done === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0 || prev_ddone === 1'b1) begin
                n_bad++;
                $display("FAIL dmem_done unexpected: got done=1 want no done");
            end else begin
                r = exp_d.pop_front();
                if (bus.dmem_rdata !== r.rdata || bus.err !== r.err) begin
                    n_bad++;
                    $display("FAIL dmem_rsp: got rdata=%h err=%b want rdata=%h err=%b",
                             bus.dmem_rdata, bus.err, r.rdata, r.err);
                end
            end
        end
        if (bus.err === 1'b1 && bus.imem_done !== 1'b1 && bus.dmem_done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL err_alone: got err=1 without done want err only with done");
        end
        prev_idone = bus.imem_done;
        prev_ddone = bus.dmem_done;

        if (bus.mem_req === 1'b1) begin
            if (!was_req) begin
                n_cmp++;
                cur_len = 1;
                unstable = 1'b0;
                h_we = bus.mem_we;
                h_addr = bus.mem_addr;
                h_wdata = bus.mem_wdata;
                if (exp_c.size() == 0) begin
                    n_bad++;
                    cur.len = 0;
                    $display("FAIL mem_cmd unexpected: got mem_req addr=%h want no request", bus.mem_addr);
                end else begin
                    cur = exp_c.pop_front();
                    if (bus.mem_we !== cur.we || bus.mem_addr !== cur.addr ||
                        (cur.chk_wdata && bus.mem_wdata !== cur.wdata)) begin
                        n_bad++;
                        $display("FAIL mem_cmd: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata, cur.we, cur.addr, cur.wdata);
                    end
                end
            end else begin
                cur_len++;
                if (bus.mem_we !== h_we || bus.mem_addr !== h_addr || bus.mem_wdata !== h_wdata)
                    unstable = 1'b1;
            end
            was_req = 1'b1;
        end else begin
            if (was_req) begin
                n_cmp++;
                if (cur_len != cur.len || unstable) begin
                    n_bad++;
                    $display("FAIL mem_hold addr=%h: got %0d cycles unstable=%b want %0d cycles stable",
                             h_addr, cur_len, unstable, cur.len);
                end
            end
            was_req = 1'b0;
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        bus.imem_req = 1'b0;
        bus.imem_addr = 32'd0;
        bus.dmem_req = 1'b0;
        bus.dmem_we = 1'b0;
        bus.dmem_addr = 32'd0;
        bus.dmem_wdata = 32'd0;
        nrst_in = 1'b1;
        #2 nrst_in = 1'b0;

        // Reset state
        repeat (2) @(negedge sysclk);
        chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst imem_rdata", bus.imem_rdata, 32'd0);
        chk("rst dmem_rdata", bus.dmem_rdata, 32'd0);
        chk("rst dones_err", {29'd0, bus.imem_done, bus.dmem_done, bus.err}, 32'd0);
        @(posedge sysclk);
        #1 nrst_in = 1'b1;
        @(posedge sysclk);
        #1;

        // Single fetch, minimum latency
        ack_delay = 0;
        push_cmd(1'b0, 32'h10, 32'd0, 1'b0, 1);
        push_rsp(1'b0, 32'h0050_0093, 1'b0);
        bus.imem_req = 1'b1;
        bus.imem_addr = 32'h10;
        wait_done(1'b0, 2, "fetch");
        bus.imem_req = 1'b0;

        // Data read, ack on second cycle
        ack_delay = 1;
        push_cmd(1'b0, 32'h24, 32'd0, 1'b0, 2);
        push_rsp(1'b1, 32'hFFFF_FFDB, 1'b0);
        bus.dmem_req = 1'b1;
        bus.dmem_we = 1'b0;
        bus.dmem_addr = 32'h24;
        wait_done(1'b1, 3, "read");
        bus.dmem_req = 1'b0;

        // Write, ack in the same cycle the timeout would fire: ack wins
        ack_delay = 3;
        push_cmd(1'b1, 32'h20, 32'hCAFE_F00D, 1'b1, 4);
        push_rsp(1'b1, 32'hFFFF_FFDB, 1'b0);
        bus.dmem_req = 1'b1;
        bus.dmem_we = 1'b1;
        bus.dmem_addr = 32'h20;
        bus.dmem_wdata = 32'hCAFE_F00D;
        wait_done(1'b1, 5, "write");
        bus.dmem_req = 1'b0;
        bus.dmem_we = 1'b0;

        // Fetch timeout: no ack ever
        ack_delay = -1;
        push_cmd(1'b0, 32'h30, 32'd0, 1'b0, 4);
        push_rsp(1'b0, 32'h0050_0093, 1'b1);
        bus.imem_req = 1'b1;
        bus.imem_addr = 32'h30;
        wait_done(1'b0, 5, "timeout");
        bus.imem_req = 1'b0;

        // Contention, both requests held
        ack_delay = 0;
        bus.imem_addr = 32'h40;
        bus.dmem_addr = 32'h80;
`ifdef MEMARB_ROUNDROBIN_EN
        push_cmd(1'b0, 32'h40, 32'd0, 1'b0, 1);
        push_cmd(1'b0, 32'h80, 32'd0, 1'b0, 1);
        push_cmd(1'b0, 32'h40, 32'd0, 1'b0, 1);
        push_cmd(1'b0, 32'h80, 32'd0, 1'b0, 1);
`else
        push_cmd(1'b0, 32'h80, 32'd0, 1'b0, 1);
        push_cmd(1'b0, 32'h40, 32'd0, 1'b0, 1);
        push_cmd(1'b0, 32'h80, 32'd0, 1'b0, 1);
        push_cmd(1'b0, 32'h40, 32'd0, 1'b0, 1);
`endif
        push_rsp(1'b1, 32'hFFFF_FF7F, 1'b0);
        push_rsp(1'b1, 32'hFFFF_FF7F, 1'b0);
        push_rsp(1'b0, 32'hFFFF_FFBF, 1'b0);
        push_rsp(1'b0, 32'hFFFF_FFBF, 1'b0);
        bus.imem_req = 1'b1;
        bus.dmem_req = 1'b1;
`ifdef MEMARB_ROUNDROBIN_EN
        wait_done(1'b0, 2, "rr first");
        wait_done(1'b1, 1, "rr second");
        wait_done(1'b0, 1, "rr third");
        bus.imem_req = 1'b0;
        wait_done(1'b1, 1, "rr fourth");
        bus.dmem_req = 1'b0;
`else
        wait_done(1'b1, 2, "prio first");
        wait_done(1'b0, 1, "prio second");
        wait_done(1'b1, 1, "prio third");
        bus.dmem_req = 1'b0;
        wait_done(1'b0, 1, "prio fourth");
        bus.imem_req = 1'b0;
`endif

        // Request dropped mid-transfer still completes
        ack_delay = 2;
        push_cmd(1'b0, 32'h50, 32'd0, 1'b0, 3);
        push_rsp(1'b0, 32'hFFFF_FFAF, 1'b0);
        bus.imem_req = 1'b1;
        bus.imem_addr = 32'h50;
        @(posedge sysclk);
        #1 bus.imem_req = 1'b0;
        wait_done(1'b0, -1, "drop");

        // Reset during a data transfer
        ack_delay = -1;
        push_cmd(1'b0, 32'h60, 32'd0, 1'b0, 2);
        bus.dmem_req = 1'b1;
        bus.dmem_addr = 32'h60;
        repeat (3) @(posedge sysclk);
        #3 nrst_in = 1'b0;
        #1;
        chk("async rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("async rst imem_rdata", bus.imem_rdata, 32'd0);
        @(posedge sysclk);
        ack_delay = 0;
        push_cmd(1'b0, 32'h60, 32'd0, 1'b0, 1);
        push_rsp(1'b1, 32'hFFFF_FF9F, 1'b0);
        @(posedge sysclk);
        #1 nrst_in = 1'b1;
        @(posedge sysclk);
        #1;
        chk("regrant mem_req", {31'd0, bus.mem_req}, 32'd1);
        wait_done(1'b1, -1, "regrant");
        bus.dmem_req = 1'b0;

        // Stray ack while idle
        @(negedge sysclk);
        force_ack = 1'b1;
        @(negedge sysclk);
        force_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sysclk);
            chk("stray mem_req", {31'd0, bus.mem_req}, 32'd0);
        end
        chk("stray imem_rdata", bus.imem_rdata, 32'd0);
        chk("stray dmem_rdata", bus.dmem_rdata, 32'hFFFF_FF9F);
        @(posedge sysclk);
        #1;

        // Arbiter still idle: a fresh fetch has minimum latency
        push_cmd(1'b0, 32'h10, 32'd0, 1'b0, 1);
        push_rsp(1'b0, 32'h0050_0093, 1'b0);
        bus.imem_req = 1'b1;
        bus.imem_addr = 32'h10;
        wait_done(1'b0, 2, "post-stray fetch");
        bus.imem_req = 1'b0;

        repeat (3) @(negedge sysclk);
        chk("left cmds", exp_c.size(), 32'd0);
        chk("left imem rsps", exp_i.size(), 32'd0);
        chk("left dmem rsps", exp_d.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
